// File: rtl/ppa_pipe.sv
// ppa_pipe: pipelined Kogge-Stone adder/subtractor with valid/ready handshake.
// Bit cells are registered in stage 0. Stages 1..S each evaluate LEVELS_PER_STAGE
// prefix levels, and stage S also forms sum/cout/ovf into the output registers.
module ppa_pipe #(
  parameter int unsigned WIDTH            = 16,
  parameter int unsigned LEVELS_PER_STAGE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned LOG2W = $clog2(WIDTH);
  localparam int unsigned S     = (LOG2W + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE;

  logic             stall;
  logic [WIDTH-1:0] yy, g0, a0, p0;
  logic             c0;

  // Stage registers: index 0 holds the bit cells, 1..S-1 hold partial prefix results.
  logic [WIDTH-1:0] g_q  [S];
  logic [WIDTH-1:0] a_q  [S];
  logic [WIDTH-1:0] p_q  [S];
  logic             c0_q [S];
  logic             xm_q [S];
  logic             ym_q [S];
  logic             v_q  [S];

  // Combinational prefix results produced by stage s from register set s-1.
  logic [WIDTH-1:0] g_c  [1:S];
  logic [WIDTH-1:0] a_c  [1:S];

  logic [WIDTH-1:0] sum_c;
  logic             ovf_c;

  // Handshake: the whole pipeline freezes while a result waits downstream.
  always_comb begin
    stall    = out_valid && !out_ready;
    in_ready = !stall;
  end

  // Per-bit generate/alive/propagate cells with the carry-in folded into bit 0.
  always_comb begin
    yy    = sub ? ~y : y;
    c0    = cin ^ sub;
    g0    = x & yy;
    a0    = x | yy;
    p0    = x ^ yy;
    g0[0] = g0[0] | (a0[0] & c0);
  end

  // Kogge-Stone levels for each stage; the last stage takes any remainder levels.
  always_comb begin
    logic [WIDTH-1:0] gt, at, gp, ap;
    gt = '0;
    at = '0;
    gp = '0;
    ap = '0;
    for (int unsigned s = 1; s <= S; s++) begin
      gt = g_q[s-1];
      at = a_q[s-1];
      for (int unsigned k = (s - 1) * LEVELS_PER_STAGE; k < s * LEVELS_PER_STAGE; k++) begin
        if (k < LOG2W) begin
          gp = gt;
          ap = at;
          for (int unsigned i = 0; i < WIDTH; i++) begin
            if (i >= (32'd1 << k)) begin
              gt[i] = gp[i] | (ap[i] & gp[i - (32'd1 << k)]);
              at[i] = ap[i] & ap[i - (32'd1 << k)];
            end
          end
        end
      end
      g_c[s] = gt;
      a_c[s] = at;
    end
  end

  // Final sum: carry into bit i is the group generate of bits i-1..0.
  always_comb begin
    sum_c = p_q[S-1] ^ {g_c[S][WIDTH-2:0], c0_q[S-1]};
    ovf_c = (xm_q[S-1] == ym_q[S-1]) && (sum_c[WIDTH-1] != xm_q[S-1]);
  end

  // Datapath registers advance whenever the pipeline is not stalled.
  always_ff @(posedge clk) begin
    if (!stall) begin
      g_q[0]  <= g0;
      a_q[0]  <= a0;
      p_q[0]  <= p0;
      c0_q[0] <= c0;
      xm_q[0] <= x[WIDTH-1];
      ym_q[0] <= yy[WIDTH-1];
      for (int unsigned s = 1; s < S; s++) begin
        g_q[s]  <= g_c[s];
        a_q[s]  <= a_c[s];
        p_q[s]  <= p_q[s-1];
        c0_q[s] <= c0_q[s-1];
        xm_q[s] <= xm_q[s-1];
        ym_q[s] <= ym_q[s-1];
      end
    end
  end

  // Valid chain and output registers; outputs only reload when a valid result arrives.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < S; s++) begin
        v_q[s] <= 1'b0;
      end
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (!stall) begin
      v_q[0] <= in_valid;
      for (int unsigned s = 1; s < S; s++) begin
        v_q[s] <= v_q[s-1];
      end
      out_valid <= v_q[S-1];
      if (v_q[S-1]) begin
        sum  <= sum_c;
        cout <= g_c[S][WIDTH-1];
        ovf  <= ovf_c;
      end
    end
  end

endmodule

// File: tb/tb_ppa_pipe.sv
// Testbench for ppa_pipe: directed arithmetic cases, latency, backpressure,
// random streams against a plain-arithmetic reference, and reset flushing.
module tb_ppa_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [15:0] x, y, sum;
  logic        b_in_valid, b_in_ready, b_cin, b_sub, b_out_valid, b_out_ready, b_cout, b_ovf;
  logic [7:0]  b_x, b_y, b_sum;

  int vectors     = 0;
  int miscompares = 0;

  ppa_pipe #(.WIDTH(16), .LEVELS_PER_STAGE(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  ppa_pipe #(.WIDTH(8), .LEVELS_PER_STAGE(1)) dut_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .x(b_x), .y(b_y), .cin(b_cin), .sub(b_sub), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .sum(b_sum), .cout(b_cout), .ovf(b_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, miscompares=%0d", miscompares);
    $fatal(1, "timeout");
  end

  // Reference result {ovf, cout, sum} from the arithmetic definition.
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic c, input logic s);
    logic [15:0] bb;
    logic [16:0] r;
    logic        v;
    bb = s ? ~b : b;
    r  = {1'b0, a} + {1'b0, bb} + {16'd0, c ^ s};
    v  = (a[15] == bb[15]) && (r[15] != a[15]);
    return {v, r};
  endfunction

  // Issue one operation on the idle 16-bit DUT and wait for its result.
  task automatic send_op(input logic [15:0] xi, input logic [15:0] yi, input logic ci,
                         input logic si, output logic [17:0] res, output int lat);
    @(negedge clk);
    x = xi; y = yi; cin = ci; sub = si; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = {ovf, cout, sum};
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b1; x = 16'h1234; y = 16'h4321; cin = 1'b0; sub = 1'b0;
    out_ready = 1'b1;
    b_in_valid = 1'b1; b_x = 8'h12; b_y = 8'h34; b_cin = 1'b0; b_sub = 1'b0; b_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({out_valid, sum, cout, ovf} !== 19'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got valid=%b sum=%h cout=%b ovf=%b, expected all zero",
               out_valid, sum, cout, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0; b_in_valid = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if ({in_ready, out_valid, b_in_ready, b_out_valid} !== 4'b1010) begin
      miscompares++;
      $display("FAIL reset_release: got in_ready=%b out_valid=%b w8 in_ready=%b out_valid=%b, expected 1 0 1 0",
               in_ready, out_valid, b_in_ready, b_out_valid);
    end
  endtask

  task automatic test_add_wrap;
    logic [17:0] r;
    int lat;
    send_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, r, lat);
    vectors++;
    if (r !== {1'b0, 1'b1, 16'h0000} || lat !== 3) begin
      miscompares++;
      $display("FAIL add_wrap: got ovf/cout/sum=%h lat=%0d, expected %h lat=3", r, lat, {1'b0, 1'b1, 16'h0000});
    end
    send_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, r, lat);
    vectors++;
    if (r !== {1'b1, 1'b0, 16'h8000} || lat !== 3) begin
      miscompares++;
      $display("FAIL add_ovf: got ovf/cout/sum=%h lat=%0d, expected %h lat=3", r, lat, {1'b1, 1'b0, 16'h8000});
    end
  endtask

  task automatic test_subtract;
    logic [15:0] tx [3];
    logic [15:0] ty [3];
    logic        tc [3];
    logic [17:0] te [3];
    logic [17:0] r;
    int lat;
    tx[0] = 16'h0005; ty[0] = 16'h0007; tc[0] = 1'b0; te[0] = {1'b0, 1'b0, 16'hFFFE};
    tx[1] = 16'h8000; ty[1] = 16'h0001; tc[1] = 1'b0; te[1] = {1'b1, 1'b1, 16'h7FFF};
    tx[2] = 16'h0010; ty[2] = 16'h0003; tc[2] = 1'b1; te[2] = {1'b0, 1'b1, 16'h000C};
    for (int i = 0; i < 3; i++) begin
      send_op(tx[i], ty[i], tc[i], 1'b1, r, lat);
      vectors++;
      if (r !== te[i] || lat !== 3) begin
        miscompares++;
        $display("FAIL subtract_%0d: got ovf/cout/sum=%h lat=%0d, expected %h lat=3", i, r, lat, te[i]);
      end
    end
  endtask

  task automatic test_carry_chain;
    logic [17:0] r;
    int lat;
    send_op(16'hAAAA, 16'h5555, 1'b1, 1'b0, r, lat);
    vectors++;
    if (r !== {1'b0, 1'b1, 16'h0000} || lat !== 3) begin
      miscompares++;
      $display("FAIL carry_chain16: got ovf/cout/sum=%h lat=%0d, expected %h lat=3", r, lat, {1'b0, 1'b1, 16'h0000});
    end
  endtask

  task automatic test_carry_chain_w8;
    int lat;
    @(negedge clk);
    b_x = 8'hAA; b_y = 8'h55; b_cin = 1'b1; b_sub = 1'b0; b_in_valid = 1'b1; b_out_ready = 1'b1;
    @(posedge clk);
    #1 b_in_valid = 1'b0;
    lat = 1;
    while (!b_out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    vectors++;
    if ({b_ovf, b_cout, b_sum} !== {1'b0, 1'b1, 8'h00} || lat !== 4) begin
      miscompares++;
      $display("FAIL carry_chain8: got ovf/cout/sum=%b/%b/%h lat=%0d, expected 0/1/00 lat=4",
               b_ovf, b_cout, b_sum, lat);
    end
  endtask

  // Random operand stream on the 16-bit DUT, checked in order against the model.
  task automatic test_stream(input string name, input int n, input int stall_at,
                             input int stall_len, input bit rnd, output int cycles);
    logic [17:0] exp_q [$];
    logic [17:0] got;
    logic [15:0] ox, oy;
    logic        oc, os, stalled;
    bit          have;
    int          sent, recv, cyc;
    have = 1'b0; sent = 0; recv = 0; cyc = 0;
    ox = '0; oy = '0; oc = 1'b0; os = 1'b0;
    while (recv < n && cyc < 400) begin
      @(negedge clk);
      if (sent < n && !have && (!rnd || $urandom_range(3) != 0)) begin
        ox = 16'($urandom); oy = 16'($urandom); oc = 1'($urandom); os = 1'($urandom);
        have = 1'b1;
      end
      x = ox; y = oy; cin = oc; sub = os; in_valid = have;
      out_ready = rnd ? ($urandom_range(3) != 0) : !(cyc >= stall_at && cyc < stall_at + stall_len);
      #1;
      stalled = out_valid && !out_ready;
      vectors++;
      if (in_ready !== !stalled) begin
        miscompares++;
        $display("FAIL %s_in_ready: cycle %0d got %b, expected %b", name, cyc, in_ready, !stalled);
      end
      if (out_valid) begin
        got = {ovf, cout, sum};
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL %s_spurious: cycle %0d got result %h, expected none", name, cyc, got);
        end else begin
          if (got !== exp_q[0]) begin
            miscompares++;
            $display("FAIL %s_result: item %0d got ovf/cout/sum=%h, expected %h", name, recv, got, exp_q[0]);
          end
          if (out_ready) begin
            void'(exp_q.pop_front());
            recv++;
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(ox, oy, oc, os));
        sent++;
        have = 1'b0;
      end
      cyc++;
    end
    vectors++;
    if (recv != n) begin
      miscompares++;
      $display("FAIL %s_count: got %0d results, expected %0d", name, recv, n);
    end
    cycles = cyc;
  endtask

  task automatic test_back_to_back;
    int cyc;
    test_stream("back_to_back", 8, 0, 0, 1'b0, cyc);
    vectors++;
    if (cyc !== 11) begin
      miscompares++;
      $display("FAIL back_to_back_throughput: got %0d cycles, expected 11", cyc);
    end
  endtask

  task automatic test_backpressure;
    int cyc;
    test_stream("backpressure", 8, 5, 2, 1'b0, cyc);
    vectors++;
    if (cyc !== 13) begin
      miscompares++;
      $display("FAIL backpressure_cycles: got %0d cycles, expected 13", cyc);
    end
  endtask

  task automatic test_random;
    int cyc;
    test_stream("random", 40, 0, 0, 1'b1, cyc);
  endtask

  task automatic test_reset_midstream;
    bit seen;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      x = 16'($urandom); y = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_loaded: got out_valid=%b, expected 1", out_valid);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_flush: got out_valid=%b in_ready=%b, expected 0 1", out_valid, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_stale: got a result after reset, expected none");
    end
  endtask

  initial begin
    test_reset();
    test_add_wrap();
    test_subtract();
    test_carry_chain();
    test_carry_chain_w8();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
